// File: rtl/pingpong_pkg.sv
// pingpong_pkg: shared width default and state encoding for the ping-pong buffer
package pingpong_pkg;
  localparam int WIDTH = 16;
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;
endpackage

// File: rtl/pingpong_buf_16b.sv
// pingpong_buf_16b: two-bank ping-pong buffer whose banks and read pointer drive an external 2:1 mux
module pingpong_buf_16b
  import pingpong_pkg::*;
#(
  parameter int WIDTH = pingpong_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic             s_o,
  output logic [1:0]       count_o
);
  state_e           state_q, state_d;
  logic             wptr_q, rptr_q;
  logic [WIDTH-1:0] bank0_q, bank1_q;
  logic             push, pop;
  assign out_valid = (state_q == ST_ONE) || (state_q == ST_FULL);
  assign in_ready  = (state_q != ST_FULL) && !rst;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign a_o       = bank0_q;
  assign b_o       = bank1_q;
  assign s_o       = rptr_q;
  assign count_o   = state_q == ST_FULL ? 2'd2 : state_q == ST_ONE ? 2'd1 : 2'd0;
  // next occupancy; flush wins over any push/pop, the unused encoding falls back to empty
  always_comb begin
    state_d = flush                 ? ST_EMPTY :
              state_q == ST_EMPTY   ? (push ? ST_ONE : ST_EMPTY) :
              state_q == ST_ONE     ? (push && !pop ? ST_FULL : !push && pop ? ST_EMPTY : ST_ONE) :
              state_q == ST_FULL    ? (pop ? ST_ONE : ST_FULL) :
                                      ST_EMPTY;
  end
  // occupancy, pointers and banks; flush clears pointers but leaves bank contents intact
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      bank0_q <= '0;
      bank1_q <= '0;
    end else if (flush) begin
      state_q <= ST_EMPTY;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push) wptr_q <= ~wptr_q;
      if (pop) rptr_q <= ~rptr_q;
      if (push && !wptr_q) bank0_q <= in_data;
      if (push && wptr_q) bank1_q <= in_data;
    end
  end
endmodule

// File: tb/tb_pingpong_buf_16b.sv
// tb_pingpong_buf_16b: directed checks of the ping-pong buffer with a behavioural 2:1 mux on its outputs
module tb_pingpong_buf_16b;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [15:0] in_data;
  logic        in_ready, out_valid, s_o;
  logic [15:0] a_o, b_o, y;
  logic [1:0]  count_o;
  int          checks = 0;
  int          failures = 0;
  always #5 clk = ~clk;
  assign y = s_o ? b_o : a_o;
  pingpong_buf_16b dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_ready(out_ready), .out_valid(out_valid),
    .a_o(a_o), .b_o(b_o), .s_o(s_o), .count_o(count_o)
  );
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1; flush = 0; in_valid = 1; in_data = 16'hFFFF; out_ready = 0;
    step(); step();
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_in_ready", 16'(in_ready), 16'd0);
    chk("rst_a", a_o, 16'h0000);
    chk("rst_b", b_o, 16'h0000);
    chk("rst_s", 16'(s_o), 16'd0);
    chk("rst_count", 16'(count_o), 16'd0);
    rst = 0; in_valid = 0;
    #1;
    chk("rel_in_ready", 16'(in_ready), 16'd1);
    step();
    chk("rel_count", 16'(count_o), 16'd0);
    chk("rel_a", a_o, 16'h0000);
    in_valid = 1; in_data = 16'h00FF;
    step();
    in_valid = 0;
    chk("one_count", 16'(count_o), 16'd1);
    chk("one_out_valid", 16'(out_valid), 16'd1);
    chk("one_a", a_o, 16'h00FF);
    chk("one_s", 16'(s_o), 16'd0);
    chk("one_y", y, 16'h00FF);
    out_ready = 1;
    step();
    out_ready = 0;
    chk("pop_count", 16'(count_o), 16'd0);
    chk("pop_s", 16'(s_o), 16'd1);
    flush = 1;
    step();
    flush = 0;
    chk("realign_s", 16'(s_o), 16'd0);
    in_valid = 1; in_data = 16'h0001;
    step();
    in_data = 16'hAAAA;
    step();
    in_valid = 0;
    chk("full_count", 16'(count_o), 16'd2);
    chk("full_in_ready", 16'(in_ready), 16'd0);
    chk("full_a", a_o, 16'h0001);
    chk("full_b", b_o, 16'hAAAA);
    in_valid = 1; in_data = 16'h1234;
    step();
    in_valid = 0;
    chk("full_reject_count", 16'(count_o), 16'd2);
    chk("full_reject_a", a_o, 16'h0001);
    chk("full_reject_b", b_o, 16'hAAAA);
    chk("order_y0", y, 16'h0001);
    out_ready = 1;
    step();
    chk("order_count1", 16'(count_o), 16'd1);
    chk("order_y1", y, 16'hAAAA);
    step();
    out_ready = 0;
    chk("order_count0", 16'(count_o), 16'd0);
    chk("order_out_valid", 16'(out_valid), 16'd0);
    in_valid = 1; in_data = 16'h0F0F;
    step();
    chk("sim_pre_y", y, 16'h0F0F);
    in_data = 16'hF0F0; out_ready = 1;
    step();
    in_valid = 0;
    chk("sim_count", 16'(count_o), 16'd1);
    chk("sim_s", 16'(s_o), 16'd1);
    chk("sim_y", y, 16'hF0F0);
    chk("sim_a", a_o, 16'h0F0F);
    step();
    out_ready = 0;
    chk("sim_drain", 16'(count_o), 16'd0);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1; in_data = 16'(i); out_ready = 1;
      chk($sformatf("wrap_in_ready%0d", i), 16'(in_ready), 16'd1);
      step();
      chk($sformatf("wrap_y%0d", i), y, 16'(i));
      chk($sformatf("wrap_s%0d", i), 16'(s_o), 16'(i % 2));
      chk($sformatf("wrap_count%0d", i), 16'(count_o), 16'd1);
    end
    in_valid = 0;
    step();
    out_ready = 0;
    chk("wrap_drain", 16'(count_o), 16'd0);
    in_valid = 1; in_data = 16'h1111;
    step();
    in_data = 16'h2222;
    step();
    in_valid = 0;
    chk("fl_pre_count", 16'(count_o), 16'd2);
    flush = 1; out_ready = 1;
    step();
    flush = 0; out_ready = 0;
    chk("fl_count", 16'(count_o), 16'd0);
    chk("fl_out_valid", 16'(out_valid), 16'd0);
    chk("fl_s", 16'(s_o), 16'd0);
    chk("fl_a", a_o, 16'h1111);
    chk("fl_b", b_o, 16'h2222);
    in_valid = 1; in_data = 16'h3333;
    step();
    in_valid = 0;
    chk("fl_wptr_a", a_o, 16'h3333);
    chk("fl_wptr_b", b_o, 16'h2222);
    chk("fl_y", y, 16'h3333);
    in_valid = 1; in_data = 16'h4444; rst = 1;
    step();
    rst = 0; in_valid = 0;
    chk("mid_rst_count", 16'(count_o), 16'd0);
    chk("mid_rst_a", a_o, 16'h0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
